psum_readout: RTL

- Downstream drain stage for the end-of-array partial-sum FIFO.
- On `start`, reads a programmed number of finished psums from the FIFO, then adds a per-channel bias, applies optional ReLU, rounds and shifts, and saturates to activation width.
- Streams results to the output activation buffer over a valid/ready handshake.
- Owns the FIFO read side: it drives the FIFO read-enable and pointer-increment and consumes the FIFO's registered read data.

---
 rtl/psum_readout_pkg.sv | 35 +++
 rtl/psum_readout_quant.sv | 60 ++++++
 rtl/psum_readout.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/psum_readout_pkg.sv
// -----------------------------------------------------------------------------
// psum_readout_pkg
// Shared definitions for the partial-sum readout path:
//   - state_e      : drain FSM encoding (IDLE / RUN / FLUSH)
//   - sat_max/min  : signed saturation bounds for a given output width
//   - round_const  : round-half-up constant added before an arithmetic shift
// -----------------------------------------------------------------------------
package psum_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Largest value representable in a signed field of out_width bits.
    function automatic int sat_max(input int out_width);
        return (32'sd1 <<< (out_width - 32'sd1)) - 32'sd1;
    endfunction

    // Smallest value representable in a signed field of out_width bits.
    function automatic int sat_min(input int out_width);
        return -(32'sd1 <<< (out_width - 32'sd1));
    endfunction

    // Half an LSB of the shifted result; zero when no shift is applied.
    function automatic int round_const(input int shift);
        if (shift > 32'sd0) begin
            return 32'sd1 <<< (shift - 32'sd1);
        end else begin
            return 32'sd0;
        end
    endfunction

endpackage

// File: rtl/psum_readout_quant.sv
// -----------------------------------------------------------------------------
// psum_quant
// Combinational quantiser: bias add, optional ReLU, round-half-up shift and
// signed saturation to OUT_WIDTH.
// Ports:
//   data_i    : signed psum
//   bias_i    : signed bias
//   relu_en_i : clamp negative sums to zero
//   q_o       : saturated signed result
// -----------------------------------------------------------------------------
module psum_quant
    import psum_readout_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 4
) (
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic signed [DATA_WIDTH-1:0] bias_i,
    input  logic                         relu_en_i,
    output logic signed [OUT_WIDTH-1:0]  q_o
);

    // Two guard bits: one for the bias add, one for the rounding add.
    localparam int SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] RND_C  = SW'(round_const(SHIFT));
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(OUT_WIDTH));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_min(OUT_WIDTH));

    logic signed [DATA_WIDTH:0] sum_s;
    logic signed [DATA_WIDTH:0] relu_s;
    logic signed [SW-1:0]       rnd_s;
    logic signed [SW-1:0]       shr_s;

    assign sum_s = {data_i[DATA_WIDTH-1], data_i} + {bias_i[DATA_WIDTH-1], bias_i};

    // ReLU: negative sums become zero when enabled.
    always_comb begin
        if (relu_en_i && sum_s[DATA_WIDTH]) begin
            relu_s = {(DATA_WIDTH + 1){1'b0}};
        end else begin
            relu_s = sum_s;
        end
    end

    assign rnd_s = {relu_s[DATA_WIDTH], relu_s} + RND_C;
    assign shr_s = rnd_s >>> SHIFT;

    // Clamp the shifted value into the signed output range.
    always_comb begin
        if (shr_s > SAT_HI) begin
            q_o = SAT_HI[OUT_WIDTH-1:0];
        end else if (shr_s < SAT_LO) begin
            q_o = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            q_o = shr_s[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/psum_readout.sv
// -----------------------------------------------------------------------------
// psum_readout
// Drains num_words psums from the partial-sum FIFO, quantises each one and
// streams the results over a valid/ready handshake.
// Ports:
//   clk1, rd_clr           : clock, async active-high clear
//   start/num_words/bias/relu_en : drain request, sampled in IDLE
//   fifo_rd_en/fifo_rd_inc : FIFO read strobe (data arrives next cycle)
//   fifo_data              : FIFO registered read data
//   out_valid/out_ready/out_data : result stream
//   busy, done             : drain in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module psum_readout
    import psum_readout_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 4,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                         clk1,
    input  logic                         rd_clr,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         num_words,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         relu_en,
    output logic                         fifo_rd_en,
    output logic                         fifo_rd_inc,
    input  logic signed [DATA_WIDTH-1:0] fifo_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         busy,
    output logic                         done
);

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]         num_q, issued_q, accepted_q;
    logic signed [DATA_WIDTH-1:0] bias_q, s1_data_q;
    logic                         relu_q;
    logic                         rd_d1_q, s1_valid_q;
    logic [1:0]                   in_flight_q, occ_q;
    logic signed [OUT_WIDTH-1:0]  skid_q [2];
    logic                         wr_ptr_q, rd_ptr_q;

    logic                         start_acc_s, rd_en_s, xfer_s, done_s;
    logic [1:0]                   used_s;
    logic signed [OUT_WIDTH-1:0]  quant_s;

    assign start_acc_s = (state_q == ST_IDLE) && start;
    assign xfer_s      = (occ_q != 2'd0) && out_ready;
    assign done_s      = (state_q == ST_FLUSH) && (accepted_q == num_q);

    // Credits held = reads in the pipe + words parked in the skid buffer.
    // A word leaving this cycle frees its credit immediately; the sum never
    // exceeds 2, so the skid buffer can always absorb what is in flight.
    assign used_s  = in_flight_q + occ_q - {1'b0, xfer_s};
    assign rd_en_s = (state_q == ST_RUN) && (issued_q != num_q) && (used_s < 2'd2);

    assign fifo_rd_en  = rd_en_s;
    assign fifo_rd_inc = rd_en_s;
    assign out_valid   = (occ_q != 2'd0);
    assign out_data    = skid_q[rd_ptr_q];
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_s;

    psum_quant #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT      (SHIFT)
    ) u_quant (
        .data_i    (s1_data_q),
        .bias_i    (bias_q),
        .relu_en_i (relu_q),
        .q_o       (quant_s)
    );

    // Next-state logic for the drain FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_words == {CNT_WIDTH{1'b0}}) ? ST_FLUSH : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issued_q == num_q) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk1 or posedge rd_clr) begin
        if (rd_clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain parameters and issue/accept counters.
    always_ff @(posedge clk1 or posedge rd_clr) begin
        if (rd_clr) begin
            num_q      <= {CNT_WIDTH{1'b0}};
            bias_q     <= {DATA_WIDTH{1'b0}};
            relu_q     <= 1'b0;
            issued_q   <= {CNT_WIDTH{1'b0}};
            accepted_q <= {CNT_WIDTH{1'b0}};
        end else if (start_acc_s) begin
            num_q      <= num_words;
            bias_q     <= bias;
            relu_q     <= relu_en;
            issued_q   <= {CNT_WIDTH{1'b0}};
            accepted_q <= {CNT_WIDTH{1'b0}};
        end else begin
            if (rd_en_s) begin
                issued_q <= issued_q + CNT_WIDTH'(1'b1);
            end
            if (xfer_s) begin
                accepted_q <= accepted_q + CNT_WIDTH'(1'b1);
            end
        end
    end

    // Read pipeline: FIFO data lands one cycle after the strobe, then S1.
    always_ff @(posedge clk1 or posedge rd_clr) begin
        if (rd_clr) begin
            rd_d1_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= {DATA_WIDTH{1'b0}};
            in_flight_q <= 2'd0;
        end else begin
            rd_d1_q     <= rd_en_s;
            s1_valid_q  <= rd_d1_q;
            if (rd_d1_q) begin
                s1_data_q <= fifo_data;
            end
            in_flight_q <= in_flight_q + {1'b0, rd_en_s} - {1'b0, s1_valid_q};
        end
    end

    // Two-entry skid buffer: S1 writes, downstream transfers read.
    always_ff @(posedge clk1 or posedge rd_clr) begin
        if (rd_clr) begin
            skid_q[0] <= {OUT_WIDTH{1'b0}};
            skid_q[1] <= {OUT_WIDTH{1'b0}};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (s1_valid_q) begin
                skid_q[wr_ptr_q] <= quant_s;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (xfer_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, s1_valid_q} - {1'b0, xfer_s};
        end
    end

endmodule
